matrix_spi_streamer: RTL and testbench

- Downstream consumer of the double-buffered matrix frame store.
- Walks the read address over one block (0..BYTES_PER_BLOCK-1) and takes the parallel per-lane bytes returned.
- Serializes them onto LANES parallel SPI data lines, mode 0, MSB first.
- Shares one SCK and one CS_n across all lanes, which drive the LED-matrix controller chains.

---
 rtl/matrix_spi_pkg.sv | 11 +
 rtl/spi_sck_gen.sv | 38 +++
 rtl/matrix_spi_streamer.sv | 169 ++++++++++++++++
 tb/tb_matrix_spi_streamer.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/matrix_spi_pkg.sv
// rtl/matrix_spi_pkg.sv - Shared state, byte type and default sizes for the matrix SPI streamer
package matrix_spi_pkg;

  typedef enum logic [1:0] {IDLE, READ, SHIFT, DONE} state_t;

  typedef logic [7:0] lane_byte_t;

  localparam int LANES_DEFAULT           = 12;
  localparam int BYTES_PER_BLOCK_DEFAULT = 2250;

endpackage

// File: rtl/spi_sck_gen.sv
// rtl/spi_sck_gen.sv - Mode-0 SCK divider; ticks mark the cycle whose closing edge moves SCK
module spi_sck_gen #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  output logic sck,
  output logic rise_tick,
  output logic fall_tick
);

  localparam int DIV_W = $clog2(CLK_DIV) + 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div_cnt;
  logic             phase_end;

  assign phase_end = enable && (div_cnt == DIV_LAST);
  assign rise_tick = phase_end && !sck;
  assign fall_tick = phase_end && sck;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt <= '0;
      sck     <= 1'b0;
    end else if (!enable) begin
      div_cnt <= '0;
      sck     <= 1'b0;
    end else if (phase_end) begin
      div_cnt <= '0;
      sck     <= ~sck;
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

endmodule

// File: rtl/matrix_spi_streamer.sv
// rtl/matrix_spi_streamer.sv - Streams one frame-store block onto LANES mode-0 SPI lines
// MATRIX_SPI_PREFETCH_EN: fetch byte n+1 while byte n shifts, removing the inter-byte READ gap.
module matrix_spi_streamer
  import matrix_spi_pkg::*;
#(
  parameter int BYTES_PER_BLOCK = BYTES_PER_BLOCK_DEFAULT,
  parameter int LANES           = LANES_DEFAULT,
  parameter int CLK_DIV         = 2,
  parameter int READ_LATENCY    = 2,
  parameter int ADDR_W          = $clog2(BYTES_PER_BLOCK)
) (
  input  logic               I_clk,
  input  logic               I_rst,
  input  logic               I_start,
  input  logic               I_data_valid,
  output logic [ADDR_W-1:0]  O_read_address,
  output logic               O_read_en,
  input  logic [LANES*8-1:0] I_data_flat,
  output logic               O_sck,
  output logic [LANES-1:0]   O_mosi,
  output logic               O_cs_n,
  output logic               O_busy,
  output logic               O_frame_done
);

  localparam int WAIT_W = $clog2(READ_LATENCY + 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(BYTES_PER_BLOCK - 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(READ_LATENCY);

  state_t            state;
  logic [ADDR_W-1:0] byte_cnt;
  logic [2:0]        bit_cnt;
  logic [WAIT_W-1:0] wait_cnt;
  lane_byte_t        shreg [LANES];
  logic              sck_en;
  logic              rise_tick;
  logic              fall_tick;
  logic              unused_rise;

  assign sck_en      = (state == SHIFT);
  assign unused_rise = rise_tick;

  spi_sck_gen #(.CLK_DIV(CLK_DIV)) u_sck_gen (
    .clk      (I_clk),
    .rst      (I_rst),
    .enable   (sck_en),
    .sck      (O_sck),
    .rise_tick(rise_tick),
    .fall_tick(fall_tick)
  );

`ifdef MATRIX_SPI_PREFETCH_EN
  lane_byte_t staging [LANES];
  logic       pf_pending;

  // The prefetched byte must land in staging before the current byte's last fall.
  if (16 * CLK_DIV <= READ_LATENCY + 1) begin : g_prefetch_too_slow
    $error("matrix_spi_streamer: 16*CLK_DIV must exceed READ_LATENCY+1 with prefetch");
  end
`endif

  always_ff @(posedge I_clk or posedge I_rst) begin
    if (I_rst) begin
      state          <= IDLE;
      O_read_address <= '0;
      O_read_en      <= 1'b0;
      O_mosi         <= '0;
      O_cs_n         <= 1'b1;
      O_busy         <= 1'b0;
      O_frame_done   <= 1'b0;
      byte_cnt       <= '0;
      bit_cnt        <= '0;
      wait_cnt       <= '0;
      for (int i = 0; i < LANES; i++) shreg[i] <= '0;
`ifdef MATRIX_SPI_PREFETCH_EN
      pf_pending <= 1'b0;
      for (int i = 0; i < LANES; i++) staging[i] <= '0;
`endif
    end else begin
      O_read_en    <= 1'b0;
      O_frame_done <= 1'b0;
      case (state)
        IDLE: begin
          if (I_start && I_data_valid) begin
            state          <= READ;
            O_busy         <= 1'b1;
            O_cs_n         <= 1'b0;
            byte_cnt       <= '0;
            O_read_address <= '0;
            O_read_en      <= 1'b1;
            wait_cnt       <= '0;
          end
        end
        READ: begin
          if (wait_cnt == WAIT_LAST) begin
            state   <= SHIFT;
            bit_cnt <= '0;
            for (int i = 0; i < LANES; i++) begin
              shreg[i]  <= I_data_flat[i*8 +: 8];
              O_mosi[i] <= I_data_flat[i*8 + 7];
            end
`ifdef MATRIX_SPI_PREFETCH_EN
            if (byte_cnt != LAST_ADDR) begin
              O_read_address <= byte_cnt + ADDR_W'(1);
              O_read_en      <= 1'b1;
              pf_pending     <= 1'b1;
              wait_cnt       <= '0;
            end
`endif
          end else begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
          end
        end
        SHIFT: begin
`ifdef MATRIX_SPI_PREFETCH_EN
          if (pf_pending) begin
            if (wait_cnt == WAIT_LAST) begin
              for (int i = 0; i < LANES; i++) staging[i] <= I_data_flat[i*8 +: 8];
              pf_pending <= 1'b0;
            end else begin
              wait_cnt <= wait_cnt + WAIT_W'(1);
            end
          end
`endif
          // MOSI only moves together with the falling SCK edge.
          if (fall_tick) begin
            bit_cnt <= bit_cnt + 3'd1;
            for (int i = 0; i < LANES; i++) begin
              shreg[i]  <= {shreg[i][6:0], 1'b0};
              O_mosi[i] <= shreg[i][6];
            end
            if (bit_cnt == 3'd7) begin
              if (byte_cnt == LAST_ADDR) begin
                state          <= DONE;
                O_cs_n         <= 1'b1;
                O_busy         <= 1'b0;
                O_frame_done   <= 1'b1;
                O_read_address <= '0;
                O_mosi         <= '0;
              end else begin
                byte_cnt <= byte_cnt + ADDR_W'(1);
`ifdef MATRIX_SPI_PREFETCH_EN
                for (int i = 0; i < LANES; i++) begin
                  shreg[i]  <= staging[i];
                  O_mosi[i] <= staging[i][7];
                end
                if (byte_cnt + ADDR_W'(1) != LAST_ADDR) begin
                  O_read_address <= byte_cnt + ADDR_W'(2);
                  O_read_en      <= 1'b1;
                  pf_pending     <= 1'b1;
                  wait_cnt       <= '0;
                end
`else
                state          <= READ;
                O_read_address <= byte_cnt + ADDR_W'(1);
                O_read_en      <= 1'b1;
                wait_cnt       <= '0;
`endif
              end
            end
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_matrix_spi_streamer.sv
// tb/tb_matrix_spi_streamer.sv - Self-checking bench for matrix_spi_streamer (4 bytes, 2 lanes)
module tb_matrix_spi_streamer;

  localparam int N       = 4;
  localparam int LANES   = 2;
  localparam int CLK_DIV = 2;
  localparam int RL      = 2;
`ifdef MATRIX_SPI_PREFETCH_EN
  localparam int FRAME_LEN = RL + 1 + N * 16 * CLK_DIV;
  localparam int MAX_GAP   = CLK_DIV;
`else
  localparam int FRAME_LEN = N * (RL + 1 + 16 * CLK_DIV);
  localparam int MAX_GAP   = RL + 1 + CLK_DIV;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic              data_valid;
  logic [1:0]        read_address;
  logic              read_en;
  logic [LANES*8-1:0] data_flat;
  logic              sck;
  logic [LANES-1:0]  mosi;
  logic              cs_n;
  logic              busy;
  logic              frame_done;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  matrix_spi_streamer #(
    .BYTES_PER_BLOCK(N), .LANES(LANES), .CLK_DIV(CLK_DIV), .READ_LATENCY(RL)
  ) dut (
    .I_clk(clk), .I_rst(rst), .I_start(start), .I_data_valid(data_valid),
    .O_read_address(read_address), .O_read_en(read_en), .I_data_flat(data_flat),
    .O_sck(sck), .O_mosi(mosi), .O_cs_n(cs_n), .O_busy(busy), .O_frame_done(frame_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Buffer model: contents mem[], data appears RL cycles after the address changes.
  logic [15:0] mem [N];
  logic [15:0] pipe [RL];
  always @(posedge clk) begin
    pipe[0] <= mem[read_address];
    for (int i = 1; i < RL; i++) pipe[i] <= pipe[i-1];
  end
  assign data_flat = pipe[RL-1];

  // Line monitor, sampled on the falling clock edge.
  int rd_en_cnt, done_cnt, done_cyc, cs_low_cnt, busy_cnt, max_addr, first_addr;
  int rise_cnt, proto_err, max_gap, high_run, low_run, since_change = 100, nbits;
  bit in_gap;
  logic prev_sck = 1'b0;
  logic [LANES-1:0] prev_mosi = '0;
  logic [7:0] acc0, acc1;
  logic [15:0] cap_q [$];

  always @(negedge clk) begin
    if (read_en) begin
      rd_en_cnt++;
      if (first_addr < 0) first_addr = int'(read_address);
    end
    if (int'(read_address) > max_addr) max_addr = int'(read_address);
    if (frame_done) begin done_cnt++; done_cyc = cyc; end
    if (!cs_n) cs_low_cnt++;
    if (busy) busy_cnt++;
    if (mosi != prev_mosi) begin
      if (sck && prev_sck) proto_err++;
      since_change = 0;
    end else begin
      since_change++;
    end
    if (sck && !prev_sck) begin
      if (since_change < CLK_DIV) proto_err++;
      if (in_gap && low_run > max_gap) max_gap = low_run;
      acc0 = {acc0[6:0], mosi[0]};
      acc1 = {acc1[6:0], mosi[1]};
      nbits++;
      if (nbits == 8) begin cap_q.push_back({acc1, acc0}); nbits = 0; end
      rise_cnt++;
      high_run = 1;
    end else if (sck) begin
      high_run++;
    end
    if (!sck && prev_sck) begin
      if (high_run != CLK_DIV) proto_err++;
      low_run = 1;
      in_gap = 1'b1;
    end else if (!sck) begin
      low_run++;
    end
    prev_sck = sck;
    prev_mosi = mosi;
  end

  task automatic clear_mon();
    @(posedge clk); #1;
    rd_en_cnt = 0; done_cnt = 0; done_cyc = 0; cs_low_cnt = 0; busy_cnt = 0;
    max_addr = 0; first_addr = -1; rise_cnt = 0; proto_err = 0; max_gap = 0;
    in_gap = 1'b0; nbits = 0; cap_q.delete();
  endtask

  task automatic pulse_start(output int acc);
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1;
    acc = cyc;
    start = 1'b0;
  endtask

  task automatic wait_done(input int base, output bit timed_out);
    timed_out = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk); #1;
      if (done_cnt > base) begin timed_out = 1'b0; break; end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; data_valid = 1'b0;
    for (int a = 0; a < N; a++) mem[a] = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (cs_n !== 1'b1) begin failures++; $display("FAIL reset_cs_n got=%b want=1", cs_n); end
    checks++; if (sck !== 1'b0) begin failures++; $display("FAIL reset_sck got=%b want=0", sck); end
    checks++; if ({busy, frame_done, read_en} !== 3'b000) begin failures++; $display("FAIL reset_flags got=%b want=000", {busy, frame_done, read_en}); end
    checks++; if ({read_address, mosi} !== 4'b0000) begin failures++; $display("FAIL reset_addr_mosi got=%h want=0", {read_address, mosi}); end
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_first_frame();
    int acc;
    bit to;
    logic [15:0] exp_words [N];
    exp_words[0] = 16'h5AC3; exp_words[1] = 16'h5BC4;
    exp_words[2] = 16'h58C5; exp_words[3] = 16'h59C6;
    for (int a = 0; a < N; a++) mem[a] = {8'h5A ^ 8'(a), 8'hC3 + 8'(a)};
    data_valid = 1'b1;
    clear_mon();
    pulse_start(acc);
    checks++; if ({busy, cs_n} !== 2'b10) begin failures++; $display("FAIL accept_busy_cs got=%b want=10", {busy, cs_n}); end
    wait_done(0, to);
    checks++; if (to !== 1'b0) begin failures++; $display("FAIL first_done_timeout got=timeout want=done"); end
    checks++; if (done_cyc - acc != FRAME_LEN) begin failures++; $display("FAIL first_len got=%0d want=%0d", done_cyc - acc, FRAME_LEN); end
    checks++; if (cs_low_cnt != FRAME_LEN) begin failures++; $display("FAIL first_cs_low got=%0d want=%0d", cs_low_cnt, FRAME_LEN); end
    checks++; if (cap_q.size() != N) begin failures++; $display("FAIL first_nbytes got=%0d want=%0d", cap_q.size(), N); end
    for (int a = 0; a < N && a < cap_q.size(); a++) begin
      checks++;
      if (cap_q[a] !== exp_words[a]) begin failures++; $display("FAIL first_byte%0d got=%h want=%h", a, cap_q[a], exp_words[a]); end
    end
    checks++; if (rd_en_cnt != N) begin failures++; $display("FAIL first_read_en got=%0d want=%0d", rd_en_cnt, N); end
    @(negedge clk); #1;
    checks++; if ({busy, cs_n, frame_done} !== 3'b010) begin failures++; $display("FAIL first_after_done got=%b want=010", {busy, cs_n, frame_done}); end
  endtask

  task automatic test_ignore_invalid();
    int acc;
    data_valid = 1'b0;
    clear_mon();
    pulse_start(acc);
    repeat (20) @(negedge clk);
    #1;
    checks++; if (busy_cnt != 0) begin failures++; $display("FAIL invalid_busy got=%0d want=0", busy_cnt); end
    checks++; if (rd_en_cnt != 0) begin failures++; $display("FAIL invalid_read_en got=%0d want=0", rd_en_cnt); end
    checks++; if (cs_low_cnt != 0) begin failures++; $display("FAIL invalid_cs got=%0d want=0", cs_low_cnt); end
  endtask

  task automatic test_start_while_busy();
    int acc;
    bit to;
    data_valid = 1'b1;
    clear_mon();
    pulse_start(acc);
    repeat (9) @(negedge clk);
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    wait_done(0, to);
    repeat (FRAME_LEN + 20) @(negedge clk);
    #1;
    checks++; if (to !== 1'b0) begin failures++; $display("FAIL busy_done_timeout got=timeout want=done"); end
    checks++; if (done_cnt != 1) begin failures++; $display("FAIL busy_done_pulses got=%0d want=1", done_cnt); end
    checks++; if (rd_en_cnt != N) begin failures++; $display("FAIL busy_read_en got=%0d want=%0d", rd_en_cnt, N); end
    checks++; if (done_cyc - acc != FRAME_LEN) begin failures++; $display("FAIL busy_len got=%0d want=%0d", done_cyc - acc, FRAME_LEN); end
  endtask

  task automatic test_reset_mid_frame();
    int acc;
    bit to;
    bit reached;
    for (int a = 0; a < N; a++) mem[a] = 16'($urandom);
    data_valid = 1'b1;
    clear_mon();
    pulse_start(acc);
    reached = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk); #1;
      if (rise_cnt >= 18) begin reached = 1'b1; break; end
    end
    checks++; if (!reached) begin failures++; $display("FAIL rst_reach_byte2 got=%0d rises want=18", rise_cnt); end
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    checks++; if ({cs_n, sck, busy} !== 3'b100) begin failures++; $display("FAIL rst_async_outputs got=%b want=100", {cs_n, sck, busy}); end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (FRAME_LEN + 20) @(negedge clk);
    #1;
    checks++; if (done_cnt != 0) begin failures++; $display("FAIL rst_no_done got=%0d want=0", done_cnt); end
    clear_mon();
    pulse_start(acc);
    wait_done(0, to);
    checks++; if (to !== 1'b0) begin failures++; $display("FAIL rst_restart_timeout got=timeout want=done"); end
    checks++; if (first_addr != 0) begin failures++; $display("FAIL rst_restart_addr got=%0d want=0", first_addr); end
    checks++; if (cap_q.size() != N) begin failures++; $display("FAIL rst_restart_nbytes got=%0d want=%0d", cap_q.size(), N); end
    for (int a = 0; a < N && a < cap_q.size(); a++) begin
      checks++;
      if (cap_q[a] !== mem[a]) begin failures++; $display("FAIL rst_restart_byte%0d got=%h want=%h", a, cap_q[a], mem[a]); end
    end
  endtask

  task automatic test_protocol();
    int acc;
    bit to;
    for (int a = 0; a < N; a++) mem[a] = 16'($urandom);
    data_valid = 1'b1;
    clear_mon();
    pulse_start(acc);
    wait_done(0, to);
    checks++; if (to !== 1'b0) begin failures++; $display("FAIL proto_timeout got=timeout want=done"); end
    checks++; if (proto_err != 0) begin failures++; $display("FAIL proto_violations got=%0d want=0", proto_err); end
    checks++; if (rise_cnt != 8 * N) begin failures++; $display("FAIL proto_rises got=%0d want=%0d", rise_cnt, 8 * N); end
    checks++; if (max_addr != N - 1) begin failures++; $display("FAIL proto_max_addr got=%0d want=%0d", max_addr, N - 1); end
    checks++; if (max_gap != MAX_GAP) begin failures++; $display("FAIL proto_byte_gap got=%0d want=%0d", max_gap, MAX_GAP); end
  endtask

  task automatic test_random_frames();
    int acc;
    bit to;
    for (int f = 0; f < 4; f++) begin
      for (int a = 0; a < N; a++) mem[a] = 16'($urandom);
      data_valid = 1'b1;
      repeat ($urandom_range(0, 7)) @(negedge clk);
      clear_mon();
      pulse_start(acc);
      if (f % 2 == 1) data_valid = 1'b0;
      wait_done(0, to);
      checks++; if (to !== 1'b0) begin failures++; $display("FAIL rand%0d_timeout got=timeout want=done", f); end
      checks++; if (done_cyc - acc != FRAME_LEN) begin failures++; $display("FAIL rand%0d_len got=%0d want=%0d", f, done_cyc - acc, FRAME_LEN); end
      checks++; if (proto_err != 0) begin failures++; $display("FAIL rand%0d_proto got=%0d want=0", f, proto_err); end
      checks++; if (cap_q.size() != N) begin failures++; $display("FAIL rand%0d_nbytes got=%0d want=%0d", f, cap_q.size(), N); end
      for (int a = 0; a < N && a < cap_q.size(); a++) begin
        checks++;
        if (cap_q[a] !== mem[a]) begin failures++; $display("FAIL rand%0d_byte%0d got=%h want=%h", f, a, cap_q[a], mem[a]); end
      end
    end
    data_valid = 1'b1;
  endtask

  initial begin
    #2_000_000;
    failures++;
    $display("FAIL watchdog got=running want=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_first_frame();
    test_ignore_invalid();
    test_start_while_busy();
    test_reset_mid_frame();
    test_protocol();
    test_random_frames();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
